qpsk_rx_demod: RTL and testbench

QPSK_RX_DEMOD -- requirements
Module: qpsk_rx_demod

---
 rtl/qpsk_pkg.sv | 25 ++
 rtl/qpsk_lane_mac.sv | 64 ++++++
 rtl/qpsk_rx_demod.sv | 186 ++++++++++++++++++
 tb/tb_qpsk_rx_demod.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK receive demodulator: phase encodings,
// controller state type and the accumulator width rule.
package qpsk_pkg;

    // Receiver phase in the transmitter's Gray order (0, 90, 180, 270 degrees)
    typedef enum logic [1:0] {
        PH_0   = 2'b00,
        PH_90  = 2'b01,
        PH_180 = 2'b11,
        PH_270 = 2'b10
    } rx_phase_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACQ   = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    // Full product, lane growth, 8 bits for up to 255 words, and headroom
    // so that negating the full-scale result stays exact.
    function automatic int acc_w_min(input int n_bits, input int n_para);
        return 2 * n_bits + $clog2(n_para) + 8;
    endfunction

endpackage

// File: rtl/qpsk_lane_mac.sv
// Per-lane signed multiply into a product register, then a registered sum
// across all lanes. One instance serves the I arm, one the Q arm.
module qpsk_lane_mac
    import qpsk_pkg::*;
#(
    parameter int N_bits = 16,
    parameter int N_para = 4,
    parameter int SUM_W  = 2 * N_bits + $clog2(N_para)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic                       ld_prod_i,
    input  logic                       ld_sum_i,
    input  logic [N_para*N_bits-1:0]   smp_i,
    input  logic [N_para*N_bits-1:0]   ref_i,
    output logic signed [SUM_W-1:0]    sum_o
);

    localparam int P_W = 2 * N_bits;

    logic signed [P_W-1:0]   prod_d [N_para];
    logic signed [P_W-1:0]   prod_q [N_para];
    logic signed [SUM_W-1:0] sum_d;
    logic signed [SUM_W-1:0] sum_q;

    // Full-precision products with both operands sign-extended explicitly
    always_comb begin
        for (int k = 0; k < N_para; k++) begin
            prod_d[k] = $signed({{N_bits{smp_i[k*N_bits+N_bits-1]}}, smp_i[k*N_bits +: N_bits]})
                      * $signed({{N_bits{ref_i[k*N_bits+N_bits-1]}}, ref_i[k*N_bits +: N_bits]});
        end
    end

    // Sign-extended sum of the registered lane products
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < N_para; k++) begin
            sum_d = sum_d + {{(SUM_W-P_W){prod_q[k][P_W-1]}}, prod_q[k]};
        end
    end

    // Product and lane-sum stages; clr_i flushes in-flight data
    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            for (int k = 0; k < N_para; k++) begin
                prod_q[k] <= '0;
            end
            sum_q <= '0;
        end else begin
            if (ld_prod_i) begin
                for (int k = 0; k < N_para; k++) begin
                    prod_q[k] <= prod_d[k];
                end
            end
            if (ld_sum_i) begin
                sum_q <= sum_d;
            end
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/qpsk_rx_demod.sv
// QPSK receive demodulator: mixes parallel ADC words against the local
// cosine/sine reference, integrates groups of words and de-rotates by the
// latched receiver phase.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; configuration latched on leaving
// ST_ACQ   | accepting valid words until n_points*decim have arrived
// ST_DRAIN | inputs ignored; waiting for the last point to leave
module qpsk_rx_demod
    import qpsk_pkg::*;
#(
    parameter int N_bits = 16,
    parameter int N_para = 4,
    parameter int ACC_W  = 42
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_para*N_bits-1:0]   adc_in,
    input  logic                       adc_valid,
    input  logic [N_para*N_bits-1:0]   dds_i,
    input  logic [N_para*N_bits-1:0]   dds_q,
    input  logic [1:0]                 rx_phase,
    input  logic                       start,
    input  logic                       abort,
    input  logic [15:0]                n_points,
    input  logic [7:0]                 decim,
    output logic signed [ACC_W-1:0]    i_out,
    output logic signed [ACC_W-1:0]    q_out,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       done
);

    localparam int SUM_W = 2 * N_bits + $clog2(N_para);

    if (ACC_W < acc_w_min(N_bits, N_para)) begin : g_acc_w_chk
        $error("ACC_W too narrow for exact accumulation and negation");
    end

    state_e                  state_q;
    rx_phase_e               phase_q;
    logic [15:0]             pts_cnt_q;
    logic [7:0]              dec_cnt_q, dec_lat_q;
    logic                    busy_q, done_q;
    logic                    v1_q, l1_q, f1_q, v2_q, l2_q, f2_q, ad_q, f3_q;
    logic signed [ACC_W-1:0] acc_i_q, acc_q_q, rot_i_d, rot_q_d, i_out_q, q_out_q;
    logic                    out_valid_q;
    logic signed [SUM_W-1:0] sum_i, sum_q;
    logic signed [ACC_W-1:0] sum_i_ext, sum_q_ext;
    logic                    flush, word_ok, grp_last, fin_word;
    logic [7:0]              dec_eff;

    assign flush    = abort && (state_q != ST_IDLE);
    assign word_ok  = (state_q == ST_ACQ) && adc_valid && (pts_cnt_q != 16'd0) && !abort;
    assign grp_last = (dec_cnt_q == 8'd1);
    assign fin_word = grp_last && (pts_cnt_q == 16'd1);
    assign dec_eff  = (decim == 8'd0) ? 8'd1 : decim;

    qpsk_lane_mac #(.N_bits(N_bits), .N_para(N_para), .SUM_W(SUM_W)) u_mac_i (
        .clk(clk), .rst_n(rst_n), .clr_i(flush), .ld_prod_i(word_ok), .ld_sum_i(v1_q),
        .smp_i(adc_in), .ref_i(dds_i), .sum_o(sum_i)
    );

    qpsk_lane_mac #(.N_bits(N_bits), .N_para(N_para), .SUM_W(SUM_W)) u_mac_q (
        .clk(clk), .rst_n(rst_n), .clr_i(flush), .ld_prod_i(word_ok), .ld_sum_i(v1_q),
        .smp_i(adc_in), .ref_i(dds_q), .sum_o(sum_q)
    );

    assign sum_i_ext = {{(ACC_W-SUM_W){sum_i[SUM_W-1]}}, sum_i};
    assign sum_q_ext = {{(ACC_W-SUM_W){sum_q[SUM_W-1]}}, sum_q};

    // Controller: configuration latch, word/point down-counters, busy and done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            phase_q   <= PH_0;
            pts_cnt_q <= '0;
            dec_cnt_q <= '0;
            dec_lat_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_q   <= ST_ACQ;
                        busy_q    <= 1'b1;
                        phase_q   <= rx_phase_e'(rx_phase);
                        pts_cnt_q <= n_points;
                        dec_lat_q <= dec_eff;
                        dec_cnt_q <= dec_eff;
                        // an empty acquisition reports done in its only ACQ cycle
                        done_q    <= (n_points == 16'd0);
                    end
                end
                ST_ACQ: begin
                    if (abort || (pts_cnt_q == 16'd0)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (word_ok) begin
                        if (grp_last) begin
                            dec_cnt_q <= dec_lat_q;
                            pts_cnt_q <= pts_cnt_q - 16'd1;
                            if (pts_cnt_q == 16'd1) begin
                                state_q <= ST_DRAIN;
                            end
                        end else begin
                            dec_cnt_q <= dec_cnt_q - 8'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (ad_q && f3_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // De-rotation by the latched receiver phase
    always_comb begin
        rot_i_d = acc_i_q;
        rot_q_d = acc_q_q;
        case (phase_q)
            PH_0:   ;
            PH_90:  begin rot_i_d = acc_q_q;  rot_q_d = -acc_i_q; end
            PH_180: begin rot_i_d = -acc_i_q; rot_q_d = -acc_q_q; end
            PH_270: begin rot_i_d = -acc_q_q; rot_q_d = acc_i_q;  end
            default: ;
        endcase
    end

    // Valid/last/final tags, accumulators and rotate/output register.
    // The accumulator holds a finished group for one cycle (ad_q); a word
    // arriving in that cycle starts the next group from zero.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            {v1_q, l1_q, f1_q, v2_q, l2_q, f2_q, ad_q, f3_q} <= '0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            i_out_q     <= '0;
            q_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            v1_q <= word_ok;
            l1_q <= word_ok && grp_last;
            f1_q <= word_ok && fin_word;
            v2_q <= v1_q;
            l2_q <= v1_q && l1_q;
            f2_q <= v1_q && f1_q;
            ad_q <= v2_q && l2_q;
            f3_q <= v2_q && f2_q;
            if (v2_q) begin
                acc_i_q <= (ad_q ? '0 : acc_i_q) + sum_i_ext;
                acc_q_q <= (ad_q ? '0 : acc_q_q) + sum_q_ext;
            end else if (ad_q) begin
                acc_i_q <= '0;
                acc_q_q <= '0;
            end
            out_valid_q <= ad_q;
            if (ad_q) begin
                i_out_q <= rot_i_d;
                q_out_q <= rot_q_d;
            end
        end
    end

    assign i_out     = i_out_q;
    assign q_out     = q_out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_qpsk_rx_demod.sv
// Directed bench for qpsk_rx_demod. A negedge monitor logs out_valid and
// done events with cycle stamps; each test task compares that log and the
// live outputs against hand-computed values.
module tb_qpsk_rx_demod;

    localparam int NB = 16;
    localparam int NP = 4;
    localparam int AW = 42;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NP*NB-1:0]     adc_in = '0;
    logic                 adc_valid = 1'b0;
    logic [NP*NB-1:0]     dds_i = '0;
    logic [NP*NB-1:0]     dds_q = '0;
    logic [1:0]           rx_phase = 2'b00;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [15:0]          n_points = '0;
    logic [7:0]           decim = '0;
    logic signed [AW-1:0] i_out, q_out;
    logic                 out_valid, busy, done;

    qpsk_rx_demod #(.N_bits(NB), .N_para(NP), .ACC_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .adc_in(adc_in), .adc_valid(adc_valid),
        .dds_i(dds_i), .dds_q(dds_q), .rx_phase(rx_phase), .start(start),
        .abort(abort), .n_points(n_points), .decim(decim), .i_out(i_out),
        .q_out(q_out), .out_valid(out_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int                   ov_cyc[$];
    logic signed [AW-1:0] ov_i[$];
    logic signed [AW-1:0] ov_q[$];
    int                   dn_cyc[$];

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            ov_cyc.push_back(cyc);
            ov_i.push_back(i_out);
            ov_q.push_back(q_out);
        end
        if (done === 1'b1) dn_cyc.push_back(cyc);
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        ov_cyc.delete();
        ov_i.delete();
        ov_q.delete();
        dn_cyc.delete();
    endtask

    task automatic set_word(input logic [15:0] a, input logic [15:0] di, input logic [15:0] dq);
        adc_in = {NP{a}};
        dds_i  = {NP{di}};
        dds_q  = {NP{dq}};
    endtask

    task automatic do_start(input logic [1:0] ph, input logic [15:0] np, input logic [7:0] dc,
                            output int sc);
        rx_phase = ph;
        n_points = np;
        decim    = dc;
        start    = 1'b1;
        sc       = cyc;
        tick();
        start    = 1'b0;
    endtask

    task automatic send(output int wc);
        adc_valid = 1'b1;
        wc        = cyc;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_chk++; if (i_out !== '0)      $display("FAIL reset_i_out got %0h want 0", i_out); else n_pass++;
        n_chk++; if (q_out !== '0)      $display("FAIL reset_q_out got %0h want 0", q_out); else n_pass++;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_chk++; if (busy !== 1'b0)     $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0)     $display("FAIL reset_done got %b want 0", done); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_phases();
        logic [1:0]           ph_t[4];
        logic signed [AW-1:0] ei[4];
        logic signed [AW-1:0] eq[4];
        logic signed [AW-1:0] p30;
        int sc, wc;
        p30 = 42'sd1 <<< 30;
        ph_t = '{2'b00, 2'b01, 2'b11, 2'b10};
        ei   = '{p30, 42'sd0, -p30, 42'sd0};
        eq   = '{42'sd0, -p30, 42'sd0, p30};
        for (int k = 0; k < 4; k++) begin
            clear_log();
            set_word(16'h4000, 16'h4000, 16'h0000);
            // decim=0 on the first pass must behave as decim=1
            do_start(ph_t[k], 16'd1, (k == 0) ? 8'd0 : 8'd1, sc);
            send(wc);
            repeat (8) tick();
            n_chk++;
            if (ov_cyc.size() != 1) $display("FAIL phase%0d_ov_count got %0d want 1", k, ov_cyc.size());
            else n_pass++;
            if (ov_cyc.size() >= 1) begin
                n_chk++;
                if (ov_cyc[0] != wc + 4) $display("FAIL phase%0d_latency got %0d want %0d", k, ov_cyc[0] - wc, 4);
                else n_pass++;
                n_chk++;
                if (ov_i[0] !== ei[k]) $display("FAIL phase%0d_i got %0d want %0d", k, ov_i[0], ei[k]);
                else n_pass++;
                n_chk++;
                if (ov_q[0] !== eq[k]) $display("FAIL phase%0d_q got %0d want %0d", k, ov_q[0], eq[k]);
                else n_pass++;
            end
            n_chk++;
            if (dn_cyc.size() != 1 || dn_cyc[0] != wc + 4)
                $display("FAIL phase%0d_done count %0d want 1 at word+4", k, dn_cyc.size());
            else n_pass++;
            n_chk++; if (busy !== 1'b0) $display("FAIL phase%0d_busy_after got %b want 0", k, busy); else n_pass++;
        end
    endtask

    task automatic test_decim255();
        logic signed [AW-1:0] e;
        int sc, wc, l1, l2;
        e = 42'sd255 <<< 32;
        l1 = 0;
        l2 = 0;
        clear_log();
        set_word(16'h8000, 16'h8000, 16'h0000);
        do_start(2'b00, 16'd2, 8'd255, sc);
        for (int w = 0; w < 510; w++) begin
            repeat ($urandom_range(0, 2)) tick();
            if (w == 100) begin
                // start and configuration changes while busy must not disturb the run
                rx_phase = 2'b01;
                n_points = 16'd7;
                decim    = 8'd3;
                start    = 1'b1;
                tick();
                start    = 1'b0;
            end
            send(wc);
            if (w == 254) l1 = wc;
            if (w == 509) l2 = wc;
        end
        repeat (8) tick();
        n_chk++;
        if (ov_cyc.size() != 2) $display("FAIL d255_ov_count got %0d want 2", ov_cyc.size());
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            if (ov_cyc.size() > k) begin
                n_chk++;
                if (ov_cyc[k] != ((k == 0) ? l1 : l2) + 4)
                    $display("FAIL d255_pt%0d_cycle got %0d want %0d", k, ov_cyc[k], ((k == 0) ? l1 : l2) + 4);
                else n_pass++;
                n_chk++;
                if (ov_i[k] !== e) $display("FAIL d255_pt%0d_i got %0d want %0d", k, ov_i[k], e);
                else n_pass++;
                n_chk++;
                if (ov_q[k] !== 42'sd0) $display("FAIL d255_pt%0d_q got %0d want 0", k, ov_q[k]);
                else n_pass++;
            end
        end
        n_chk++;
        if (dn_cyc.size() != 1 || dn_cyc[0] != l2 + 4)
            $display("FAIL d255_done count %0d want 1 at last word+4", dn_cyc.size());
        else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL d255_busy_after got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_npoints0();
        int sc;
        clear_log();
        set_word(16'h4000, 16'h4000, 16'h0000);
        do_start(2'b00, 16'd0, 8'd1, sc);
        n_chk++; if (done !== 1'b1) $display("FAIL np0_done got %b want 1", done); else n_pass++;
        adc_valid = 1'b1;
        repeat (6) tick();
        adc_valid = 1'b0;
        repeat (4) tick();
        n_chk++; if (ov_cyc.size() != 0) $display("FAIL np0_ov_count got %0d want 0", ov_cyc.size()); else n_pass++;
        n_chk++;
        if (dn_cyc.size() != 1 || dn_cyc[0] != sc + 1)
            $display("FAIL np0_done_once count %0d want 1 at start+1", dn_cyc.size());
        else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL np0_busy_after got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_start_abort_idle();
        clear_log();
        n_points = 16'd1;
        decim    = 8'd1;
        start    = 1'b1;
        abort    = 1'b1;
        tick();
        start    = 1'b0;
        abort    = 1'b0;
        n_chk++; if (busy !== 1'b0) $display("FAIL start_abort_busy got %b want 0", busy); else n_pass++;
        repeat (5) tick();
        n_chk++;
        if (ov_cyc.size() != 0 || dn_cyc.size() != 0)
            $display("FAIL start_abort_events got ov %0d done %0d want 0 0", ov_cyc.size(), dn_cyc.size());
        else n_pass++;
    endtask

    task automatic test_cancel(input bit use_rst);
        logic signed [AW-1:0] p30, p31, fi, fq;
        logic [1:0] ph;
        int sc, wc;
        p30 = 42'sd1 <<< 30;
        p31 = 42'sd1 <<< 31;
        clear_log();
        set_word(16'h4000, 16'h4000, 16'h2000);
        do_start(2'b00, 16'd5, 8'd2, sc);
        repeat (4) send(wc);
        repeat (6) tick();
        send(wc);                    // first word of the 3rd point
        if (use_rst) rst_n = 1'b0; else abort = 1'b1;
        tick();
        rst_n = 1'b1;
        abort = 1'b0;
        n_chk++; if (busy !== 1'b0) $display("FAIL cancel%0d_busy got %b want 0", use_rst, busy); else n_pass++;
        adc_valid = 1'b1;
        repeat (6) tick();
        adc_valid = 1'b0;
        repeat (4) tick();
        n_chk++;
        if (ov_cyc.size() != 2) $display("FAIL cancel%0d_ov_count got %0d want 2", use_rst, ov_cyc.size());
        else n_pass++;
        if (ov_cyc.size() >= 1) begin
            n_chk++;
            if (ov_i[0] !== p31 || ov_q[0] !== p30)
                $display("FAIL cancel%0d_pt1 got (%0d,%0d) want (%0d,%0d)", use_rst, ov_i[0], ov_q[0], p31, p30);
            else n_pass++;
        end
        n_chk++; if (dn_cyc.size() != 0) $display("FAIL cancel%0d_no_done got %0d want 0", use_rst, dn_cyc.size()); else n_pass++;

        // fresh acquisition after the cancel must not see the partial group
        ph = use_rst ? 2'b01 : 2'b11;
        fi = use_rst ? p30 : -p31;
        fq = use_rst ? -p31 : -p30;
        clear_log();
        do_start(ph, 16'd1, 8'd2, sc);
        send(wc);
        send(wc);
        repeat (8) tick();
        n_chk++;
        if (ov_cyc.size() != 1) $display("FAIL cancel%0d_fresh_count got %0d want 1", use_rst, ov_cyc.size());
        else n_pass++;
        if (ov_cyc.size() >= 1) begin
            n_chk++;
            if (ov_i[0] !== fi || ov_q[0] !== fq)
                $display("FAIL cancel%0d_fresh got (%0d,%0d) want (%0d,%0d)", use_rst, ov_i[0], ov_q[0], fi, fq);
            else n_pass++;
        end
        n_chk++;
        if (dn_cyc.size() != 1 || dn_cyc[0] != wc + 4)
            $display("FAIL cancel%0d_fresh_done count %0d want 1 at word+4", use_rst, dn_cyc.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_phases();
        test_npoints0();
        test_start_abort_idle();
        test_decim255();
        test_cancel(1'b0);
        test_cancel(1'b1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1);
    end

endmodule
